stopwatch_ctrl: RTL

//  Stopwatch control and timebase stage, directly downstream of the button debouncers.

---
 rtl/stopwatch_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM and MM:SS.CC BCD timebase, fed by one-cycle debounced button pulses.
// Digit outputs show the frozen lap capture while in LAP and the live count otherwise.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       lap_reset,
   output logic [2:0] min_t,
   output logic [3:0] min_o,
   output logic [2:0] sec_t,
   output logic [3:0] sec_o,
   output logic [3:0] cs_t,
   output logic [3:0] cs_o,
   output logic       running,
   output logic       lap_mode,
   output logic       overflow
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [21:0]     r_live;
   logic [21:0]     r_lap;
   logic            r_overflow;
   logic [21:0]     w_live_inc;
   logic [21:0]     w_disp;
   logic            w_count_en;
   logic            w_tick;
   logic            w_wrap;
   logic            w_capture;
   logic            w_clear;
   logic [2:0]      w_mt;
   logic [3:0]      w_mo;
   logic [2:0]      w_st;
   logic [3:0]      w_so;
   logic [3:0]      w_ct;
   logic [3:0]      w_co;

   // start_stop is checked first in every state, so a simultaneous lap_reset is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         StIdle: begin
            if (start_stop) w_state_nxt = StRun;
         end
         StRun: begin
            if (start_stop) begin
               w_state_nxt = StPause;
            end else if (lap_reset) begin
               w_state_nxt = StLap;
               w_capture   = 1'b1;
            end
         end
         StLap: begin
            if (start_stop) begin
               w_state_nxt = StPause;
            end else if (lap_reset) begin
               w_state_nxt = StRun;
            end
         end
         StPause: begin
            if (start_stop) begin
               w_state_nxt = StRun;
            end else if (lap_reset) begin
               w_state_nxt = StIdle;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign w_count_en = (r_state == StRun) || (r_state == StLap);
   assign w_tick     = w_count_en && (r_presc == PRESC_LAST);

   always_comb begin
      {w_mt, w_mo, w_st, w_so, w_ct, w_co} = r_live;
      w_wrap = 1'b0;
      if (w_co != 4'd9) begin
         w_co = w_co + 4'd1;
      end else begin
         w_co = 4'd0;
         if (w_ct != 4'd9) begin
            w_ct = w_ct + 4'd1;
         end else begin
            w_ct = 4'd0;
            if (w_so != 4'd9) begin
               w_so = w_so + 4'd1;
            end else begin
               w_so = 4'd0;
               if (w_st != 3'd5) begin
                  w_st = w_st + 3'd1;
               end else begin
                  w_st = 3'd0;
                  if (w_mo != 4'd9) begin
                     w_mo = w_mo + 4'd1;
                  end else begin
                     w_mo = 4'd0;
                     if (w_mt != 3'd5) begin
                        w_mt = w_mt + 3'd1;
                     end else begin
                        w_mt   = 3'd0;
                        w_wrap = 1'b1;
                     end
                  end
               end
            end
         end
      end
      w_live_inc = {w_mt, w_mo, w_st, w_so, w_ct, w_co};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_overflow <= w_tick & w_wrap;
      end
   end

   // Prescaler holds while paused so a resume keeps the partial tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_clear) begin
         r_presc <= '0;
      end else if (w_count_en) begin
         r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_live <= '0;
      end else if (w_clear) begin
         r_live <= '0;
      end else if (w_tick) begin
         r_live <= w_live_inc;
      end
   end

   // Capture takes the pre-increment live value even if a tick lands on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lap <= '0;
      end else if (w_clear) begin
         r_lap <= '0;
      end else if (w_capture) begin
         r_lap <= r_live;
      end
   end

   assign w_disp = (r_state == StLap) ? r_lap : r_live;
   assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = w_disp;
   assign running  = w_count_en;
   assign lap_mode = (r_state == StLap);
   assign overflow = r_overflow;

endmodule
